controle_ula_mc: RTL and testbench

Multi-cycle ULA controller: accepts an operation request (ALUOp, funct, two operands) over a valid/ready handshake, drives the ULA's `controladorULA`/`dados1`/`dados2` inputs, and captures its `saida`/`zero` back into a registered result. It is the initiator side of the ULA interface. It replaces direct combinational ALU control, so the datapath can run multi-cycle operations such as shift-add multiplication on the single shared ULA.

---
 rtl/controle_ula_mc_pkg.sv | 40 ++++
 rtl/controle_ula_mc_if.sv | 46 ++++
 rtl/controle_ula_mc_decodificador_ula.sv | 41 ++++
 rtl/controle_ula_mc.sv | 138 +++++++++++++
 tb/tb_controle_ula_mc.sv | 224 ++++++++++++++++++++++
 5 files changed

// File: rtl/controle_ula_mc_pkg.sv
// Shared ULA definitions: operation codes, aluop/funct encodings and the
// controller state enum. Imported by the decoder, the interfaces and the top.
package pacote_ula;

  // Default operand/result width (also the multiplication iteration count)
  localparam int LARGURA_PADRAO = 32;

  // ULA operation codes
  typedef enum logic [3:0] {
    ULA_AND = 4'b0000,
    ULA_OR  = 4'b0001,
    ULA_ADD = 4'b0010,
    ULA_SUB = 4'b0110,
    ULA_SLT = 4'b0111,
    ULA_NOP = 4'b1111
  } codigo_ula_t;

  // aluop encodings from the main control
  localparam logic [1:0] ALUOP_ADD      = 2'b00;
  localparam logic [1:0] ALUOP_SUB      = 2'b01;
  localparam logic [1:0] ALUOP_FUNCT    = 2'b10;
  localparam logic [1:0] ALUOP_INVALIDO = 2'b11;

  // R-type funct field values
  localparam logic [5:0] FUNCT_ADD  = 6'b100000;
  localparam logic [5:0] FUNCT_SUB  = 6'b100010;
  localparam logic [5:0] FUNCT_AND  = 6'b100100;
  localparam logic [5:0] FUNCT_OR   = 6'b100101;
  localparam logic [5:0] FUNCT_SLT  = 6'b101010;
  localparam logic [5:0] FUNCT_MULT = 6'b011000;

  // Controller states
  typedef enum logic [1:0] {
    OCIOSO = 2'd0,
    EXEC   = 2'd1,
    MULT   = 2'd2,
    FIM    = 2'd3
  } estado_t;

endpackage

// File: rtl/controle_ula_mc_if.sv
// Interfaces of the multi-cycle ULA controller.
//   controle_ula_mc_req_if : request/result side (master = requester).
//   controle_ula_mc_ula_if : ULA side (master = controller, slave = ULA).
interface controle_ula_mc_req_if import pacote_ula::*; #(
  parameter int LARGURA = LARGURA_PADRAO
);
  logic               req_valido;
  logic               req_pronto;
  logic [1:0]         aluop;
  logic [5:0]         funct;
  logic [LARGURA-1:0] opA;
  logic [LARGURA-1:0] opB;
  logic [LARGURA-1:0] resultado;
  logic               zero;
  logic               resultado_valido;

  modport master (
    output req_valido, aluop, funct, opA, opB,
    input  req_pronto, resultado, zero, resultado_valido
  );

  modport slave (
    input  req_valido, aluop, funct, opA, opB,
    output req_pronto, resultado, zero, resultado_valido
  );
endinterface

interface controle_ula_mc_ula_if import pacote_ula::*; #(
  parameter int LARGURA = LARGURA_PADRAO
);
  logic [3:0]         controladorULA;
  logic [LARGURA-1:0] dados1;
  logic [LARGURA-1:0] dados2;
  logic [LARGURA-1:0] saida_ula;
  logic               zero_ula;

  modport master (
    output controladorULA, dados1, dados2,
    input  saida_ula, zero_ula
  );

  modport slave (
    input  controladorULA, dados1, dados2,
    output saida_ula, zero_ula
  );
endinterface

// File: rtl/controle_ula_mc_decodificador_ula.sv
// Combinational (aluop, funct) -> 4-bit ULA code decoder, shared with the
// single-cycle datapath. The eh_mult flag exists only when
// CONTROLE_ULA_MULT_EN is defined; otherwise funct 011000 is unsupported.
module decodificador_ula import pacote_ula::*; (
  input  logic [1:0] aluop,
  input  logic [5:0] funct,
  output logic [3:0] codigo
`ifdef CONTROLE_ULA_MULT_EN
  ,
  output logic       eh_mult
`endif
);

  // Decode operation class and funct field; unknown combinations give NOP
  always_comb begin
    codigo = ULA_NOP;
`ifdef CONTROLE_ULA_MULT_EN
    eh_mult = 1'b0;
`endif
    case (aluop)
      ALUOP_ADD: codigo = ULA_ADD;
      ALUOP_SUB: codigo = ULA_SUB;
      ALUOP_FUNCT: begin
        case (funct)
          FUNCT_ADD: codigo = ULA_ADD;
          FUNCT_SUB: codigo = ULA_SUB;
          FUNCT_AND: codigo = ULA_AND;
          FUNCT_OR:  codigo = ULA_OR;
          FUNCT_SLT: codigo = ULA_SLT;
`ifdef CONTROLE_ULA_MULT_EN
          // The ULA itself has no multiply; the controller sequences it
          FUNCT_MULT: eh_mult = 1'b1;
`endif
          default:   codigo = ULA_NOP;
        endcase
      end
      default: codigo = ULA_NOP;
    endcase
  end

endmodule

// File: rtl/controle_ula_mc.sv
// Multi-cycle ULA controller. Accepts a request over valid/ready, drives the
// shared combinational ULA and registers its result. Optional shift-add
// multiplication is built when CONTROLE_ULA_MULT_EN is defined.
module controle_ula_mc import pacote_ula::*; #(
  parameter int LARGURA = LARGURA_PADRAO
) (
  input  logic                  clock,
  input  logic                  reset,
  controle_ula_mc_req_if.slave  req,
  controle_ula_mc_ula_if.master ula
);

  estado_t            r_estado;
  estado_t            w_estado_next;
  logic [3:0]         r_codigo;
  logic [3:0]         w_codigo;
  // In MULT, r_opA is the multiplicand (shifted left) and r_opB the
  // multiplier (shifted right)
  logic [LARGURA-1:0] r_opA;
  logic [LARGURA-1:0] r_opB;
  logic [LARGURA-1:0] r_resultado;
  logic               r_zero;

`ifdef CONTROLE_ULA_MULT_EN
  localparam int CW = $clog2(LARGURA + 1);
  logic               w_eh_mult;
  logic [LARGURA-1:0] r_acumulador;
  logic [CW-1:0]      r_contador;
`endif

  decodificador_ula u_decodificador (
    .aluop  (req.aluop),
    .funct  (req.funct),
    .codigo (w_codigo)
`ifdef CONTROLE_ULA_MULT_EN
    ,
    .eh_mult(w_eh_mult)
`endif
  );

  assign req.resultado = r_resultado;
  assign req.zero      = r_zero;

  // State register; reset aborts any operation in progress
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_estado <= OCIOSO;
    else       r_estado <= w_estado_next;
  end

  // Next state and ULA/handshake outputs, decoded from the current state
  always_comb begin
    w_estado_next        = r_estado;
    req.req_pronto       = 1'b0;
    req.resultado_valido = 1'b0;
    ula.controladorULA   = ULA_AND;
    ula.dados1           = '0;
    ula.dados2           = '0;
    case (r_estado)
      OCIOSO: begin
        req.req_pronto = 1'b1;
        if (req.req_valido) begin
`ifdef CONTROLE_ULA_MULT_EN
          w_estado_next = w_eh_mult ? MULT : EXEC;
`else
          w_estado_next = EXEC;
`endif
        end
      end
      EXEC: begin
        ula.controladorULA = r_codigo;
        ula.dados1         = r_opA;
        ula.dados2         = r_opB;
        w_estado_next      = FIM;
      end
`ifdef CONTROLE_ULA_MULT_EN
      MULT: begin
        ula.controladorULA = ULA_ADD;
        ula.dados1         = r_acumulador;
        ula.dados2         = r_opB[0] ? r_opA : '0;
        if (r_contador == CW'(1)) w_estado_next = FIM;
      end
`endif
      FIM: begin
        req.resultado_valido = 1'b1;
        w_estado_next        = OCIOSO;
      end
      default: w_estado_next = OCIOSO;
    endcase
  end

  // Operand latching, result capture and multiplication iteration
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_codigo     <= '0;
      r_opA        <= '0;
      r_opB        <= '0;
      r_resultado  <= '0;
      r_zero       <= 1'b0;
`ifdef CONTROLE_ULA_MULT_EN
      r_acumulador <= '0;
      r_contador   <= '0;
`endif
    end else begin
      case (r_estado)
        OCIOSO: begin
          if (req.req_valido) begin
            r_codigo     <= w_codigo;
            r_opA        <= req.opA;
            r_opB        <= req.opB;
`ifdef CONTROLE_ULA_MULT_EN
            r_acumulador <= '0;
            r_contador   <= CW'(LARGURA);
`endif
          end
        end
        EXEC: begin
          r_resultado <= ula.saida_ula;
          r_zero      <= ula.zero_ula;
        end
`ifdef CONTROLE_ULA_MULT_EN
        MULT: begin
          // Fixed LARGURA iterations; overflow beyond LARGURA bits is dropped
          r_acumulador <= ula.saida_ula;
          r_opA        <= r_opA << 1;
          r_opB        <= r_opB >> 1;
          r_contador   <= r_contador - CW'(1);
          if (r_contador == CW'(1)) begin
            r_resultado <= ula.saida_ula;
            r_zero      <= (ula.saida_ula == '0);
          end
        end
`endif
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_controle_ula_mc.sv
// Directed bench for controle_ula_mc with a combinational ULA model.
// Multiplication steps are compiled when CONTROLE_ULA_MULT_EN is defined;
// otherwise the unsupported-mult path is exercised.
module tb_controle_ula_mc;
  import pacote_ula::*;

  localparam int LARGURA = 32;

  logic clock;
  logic reset;
  int   n_checks = 0;
  int   n_err    = 0;
  logic visto_valido;

  controle_ula_mc_req_if #(.LARGURA(LARGURA)) req_if ();
  controle_ula_mc_ula_if #(.LARGURA(LARGURA)) ula_if ();

  controle_ula_mc #(.LARGURA(LARGURA)) dut (
    .clock(clock),
    .reset(reset),
    .req  (req_if),
    .ula  (ula_if)
  );

  initial clock = 1'b0;
  always #5 clock = ~clock;

  // Combinational ULA: and/or/add/sub/slt, anything else returns 0
  always_comb begin
    case (ula_if.controladorULA)
      4'b0000: ula_if.saida_ula = ula_if.dados1 & ula_if.dados2;
      4'b0001: ula_if.saida_ula = ula_if.dados1 | ula_if.dados2;
      4'b0010: ula_if.saida_ula = ula_if.dados1 + ula_if.dados2;
      4'b0110: ula_if.saida_ula = ula_if.dados1 - ula_if.dados2;
      4'b0111: ula_if.saida_ula = ($signed(ula_if.dados1) < $signed(ula_if.dados2)) ? 32'd1 : 32'd0;
      default: ula_if.saida_ula = 32'd0;
    endcase
    ula_if.zero_ula = (ula_if.saida_ula == 32'd0);
  end

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    assert (obs === exp) else begin
      n_err++;
      $error("FAIL %s: observed=0x%08h expected=0x%08h", tag, obs, exp);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "/pronto"}, 32'(req_if.req_pronto), 32'd1);
    chk({tag, "/ctrl"},   32'(ula_if.controladorULA), 32'd0);
    chk({tag, "/dados1"}, ula_if.dados1, 32'd0);
    chk({tag, "/dados2"}, ula_if.dados2, 32'd0);
    chk({tag, "/res"},    req_if.resultado, 32'd0);
    chk({tag, "/zero"},   32'(req_if.zero), 32'd0);
    chk({tag, "/valido"}, 32'(req_if.resultado_valido), 32'd0);
  endtask

  // Called at a negedge in OCIOSO; returns at the negedge of the next OCIOSO cycle
  task automatic opera_simples(input string tag, input logic [1:0] aluop, input logic [5:0] funct,
                               input logic [31:0] a, input logic [31:0] b,
                               input logic [3:0] cod, input logic [31:0] res, input logic z);
    req_if.aluop      = aluop;
    req_if.funct      = funct;
    req_if.opA        = a;
    req_if.opB        = b;
    req_if.req_valido = 1'b1;
    chk({tag, "/pronto_ini"}, 32'(req_if.req_pronto), 32'd1);
    @(negedge clock);
    req_if.req_valido = 1'b0;
    chk({tag, "/ctrl"},       32'(ula_if.controladorULA), 32'(cod));
    chk({tag, "/dados1"},     ula_if.dados1, a);
    chk({tag, "/dados2"},     ula_if.dados2, b);
    chk({tag, "/pronto_exec"}, 32'(req_if.req_pronto), 32'd0);
    chk({tag, "/valido_exec"}, 32'(req_if.resultado_valido), 32'd0);
    @(negedge clock);
    chk({tag, "/valido_fim"}, 32'(req_if.resultado_valido), 32'd1);
    chk({tag, "/res"},        req_if.resultado, res);
    chk({tag, "/zero"},       32'(req_if.zero), 32'(z));
    @(negedge clock);
    chk({tag, "/valido_pos"}, 32'(req_if.resultado_valido), 32'd0);
    chk({tag, "/pronto_pos"}, 32'(req_if.req_pronto), 32'd1);
    chk({tag, "/res_hold"},   req_if.resultado, res);
    chk({tag, "/ctrl_pos"},   32'(ula_if.controladorULA), 32'd0);
    $display("op %s: aluop=%b funct=%b A=0x%08h B=0x%08h -> resultado=0x%08h zero=%0b",
             tag, aluop, funct, a, b, req_if.resultado, req_if.zero);
  endtask

  // Assert reset at the current negedge, check outputs at once, then make
  // sure no result pulse appears afterwards
  task automatic reset_meio(input string tag);
    reset = 1'b1;
    req_if.req_valido = 1'b0;
    #1;
    chk_reset(tag);
    @(negedge clock);
    reset = 1'b0;
    visto_valido = 1'b0;
    for (int k = 0; k < LARGURA + 4; k++) begin
      @(negedge clock);
      if (req_if.resultado_valido) visto_valido = 1'b1;
    end
    chk({tag, "/sem_pulso"}, 32'(visto_valido), 32'd0);
    chk({tag, "/pronto"},    32'(req_if.req_pronto), 32'd1);
    $display("reset %s: aborted, resultado=0x%08h", tag, req_if.resultado);
  endtask

`ifdef CONTROLE_ULA_MULT_EN
  task automatic opera_mult(input string tag, input logic [31:0] a, input logic [31:0] b,
                            input logic [31:0] d2_ini, input logic [31:0] res, input logic z,
                            input logic injeta);
    req_if.aluop      = 2'b10;
    req_if.funct      = 6'b011000;
    req_if.opA        = a;
    req_if.opB        = b;
    req_if.req_valido = 1'b1;
    chk({tag, "/pronto_ini"}, 32'(req_if.req_pronto), 32'd1);
    for (int i = 1; i <= LARGURA; i++) begin
      @(negedge clock);
      if (i == 1) req_if.req_valido = 1'b0;
      chk({tag, "/pronto_mult"}, 32'(req_if.req_pronto), 32'd0);
      chk({tag, "/valido_mult"}, 32'(req_if.resultado_valido), 32'd0);
      if (i == 1) begin
        chk({tag, "/ctrl"},   32'(ula_if.controladorULA), 32'd2);
        chk({tag, "/acc0"},   ula_if.dados1, 32'd0);
        chk({tag, "/dados2"}, ula_if.dados2, d2_ini);
      end
      if (injeta && i == 5) begin
        req_if.aluop      = 2'b00;
        req_if.funct      = 6'b000000;
        req_if.opA        = 32'd1;
        req_if.opB        = 32'd1;
        req_if.req_valido = 1'b1;
      end
    end
    @(negedge clock);
    chk({tag, "/valido_fim"}, 32'(req_if.resultado_valido), 32'd1);
    chk({tag, "/res"},        req_if.resultado, res);
    chk({tag, "/zero"},       32'(req_if.zero), 32'(z));
    chk({tag, "/pronto_fim"}, 32'(req_if.req_pronto), 32'd0);
    @(negedge clock);
    chk({tag, "/valido_pos"}, 32'(req_if.resultado_valido), 32'd0);
    chk({tag, "/pronto_pos"}, 32'(req_if.req_pronto), 32'd1);
    $display("op %s: mult A=0x%08h B=0x%08h -> resultado=0x%08h zero=%0b",
             tag, a, b, req_if.resultado, req_if.zero);
  endtask
`endif

  initial begin
    reset             = 1'b1;
    req_if.req_valido = 1'b0;
    req_if.aluop      = 2'b00;
    req_if.funct      = 6'b000000;
    req_if.opA        = 32'd0;
    req_if.opB        = 32'd0;

    @(negedge clock);
    chk_reset("reset_ini");
    reset = 1'b0;

    opera_simples("add_funct", 2'b10, 6'b100000, 32'd5,      32'd7,      4'b0010, 32'd12,     1'b0);
    opera_simples("sub_igual", 2'b01, 6'b000000, 32'h1234,   32'h1234,   4'b0110, 32'd0,      1'b1);
    opera_simples("slt",       2'b10, 6'b101010, 32'd3,      32'd9,      4'b0111, 32'd1,      1'b0);
    opera_simples("and",       2'b10, 6'b100100, 32'hF0F0,   32'hFF00,   4'b0000, 32'hF000,   1'b0);
    opera_simples("or",        2'b10, 6'b100101, 32'hF0F0,   32'h0F00,   4'b0001, 32'hFFF0,   1'b0);
    opera_simples("add_wrap",  2'b00, 6'b000000, 32'hFFFFFFFF, 32'd1,    4'b0010, 32'd0,      1'b1);
    opera_simples("sub_funct", 2'b10, 6'b100010, 32'd10,     32'd3,      4'b0110, 32'd7,      1'b0);
    opera_simples("aluop11",   2'b11, 6'b100000, 32'd5,      32'd7,      4'b1111, 32'd0,      1'b1);
    opera_simples("add_pre",   2'b10, 6'b100000, 32'd2,      32'd3,      4'b0010, 32'd5,      1'b0);
    opera_simples("funct_inv", 2'b10, 6'b000000, 32'd5,      32'd7,      4'b1111, 32'd0,      1'b1);

`ifdef CONTROLE_ULA_MULT_EN
    opera_mult("mult_6x7",   32'd6,        32'd7, 32'd6, 32'd42,        1'b0, 1'b0);
    opera_mult("mult_maxx2", 32'hFFFFFFFF, 32'd2, 32'd0, 32'hFFFFFFFE, 1'b0, 1'b0);
    // Second request raised during MULT; accepted once back in OCIOSO
    opera_mult("mult_inj",   32'd6,        32'd7, 32'd6, 32'd42,        1'b0, 1'b1);
    @(negedge clock);
    req_if.req_valido = 1'b0;
    chk("inj/ctrl",   32'(ula_if.controladorULA), 32'd2);
    chk("inj/dados1", ula_if.dados1, 32'd1);
    chk("inj/dados2", ula_if.dados2, 32'd1);
    @(negedge clock);
    chk("inj/valido", 32'(req_if.resultado_valido), 32'd1);
    chk("inj/res",    req_if.resultado, 32'd2);
    @(negedge clock);
    chk("inj/pronto", 32'(req_if.req_pronto), 32'd1);
    $display("op inj: add A=1 B=1 -> resultado=0x%08h", req_if.resultado);

    // Reset at MULT iteration 10
    req_if.aluop      = 2'b10;
    req_if.funct      = 6'b011000;
    req_if.opA        = 32'd6;
    req_if.opB        = 32'd7;
    req_if.req_valido = 1'b1;
    for (int i = 1; i <= 10; i++) begin
      @(negedge clock);
      req_if.req_valido = 1'b0;
    end
    chk("rst_mult/pronto_antes", 32'(req_if.req_pronto), 32'd0);
    reset_meio("rst_mult");
`else
    opera_simples("add_pre2",  2'b00, 6'b000000, 32'd1,      32'd2,      4'b0010, 32'd3,      1'b0);
    opera_simples("mult_off",  2'b10, 6'b011000, 32'd6,      32'd7,      4'b1111, 32'd0,      1'b1);
    opera_simples("add_pre3",  2'b10, 6'b100000, 32'd5,      32'd7,      4'b0010, 32'd12,     1'b0);

    // Reset during EXEC
    req_if.aluop      = 2'b00;
    req_if.funct      = 6'b000000;
    req_if.opA        = 32'd2;
    req_if.opB        = 32'd2;
    req_if.req_valido = 1'b1;
    @(negedge clock);
    req_if.req_valido = 1'b0;
    chk("rst_exec/pronto_antes", 32'(req_if.req_pronto), 32'd0);
    reset_meio("rst_exec");
`endif

    opera_simples("pos_reset", 2'b10, 6'b100000, 32'd5,      32'd7,      4'b0010, 32'd12,     1'b0);

    $display("Result: errors=%0d of %0d checks", n_err, n_checks);
    $finish;
  end

endmodule
